// File: rtl/execute_seq.sv
// execute_seq: sequential, handshaked execute-stage ALU.
//
// Single-cycle ops produce their result on the accept edge. MUL, DIVU and
// REMU iterate one step per cycle for XLEN cycles. Results are held in a
// registered output until the consumer takes them.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (ALUcrl, ALU_src_a, ALU_src_b)
//   out_valid / out_ready result handshake (ALUOut, zero)
//   ALUOut               registered result
//   zero                 ALUOut == 0, decoded from the result register
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no result held, ready to accept an op
// MUL   | shift-add multiply in progress
// DIV   | restoring unsigned divide in progress
// HOLD  | result valid on ALUOut, waiting for out_ready
module execute_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUcrl,
  input  logic [XLEN-1:0] ALU_src_a,
  input  logic [XLEN-1:0] ALU_src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUOut,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_HOLD
  } state_t;

  state_t          state;
  logic [SHW-1:0]  cnt;
  // MUL: op_a = shifted multiplicand, op_b = shifted multiplier, acc = product.
  // DIV: op_a = dividend shifting out / quotient shifting in, op_b = divisor,
  //      acc = partial remainder.
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] acc;
  logic            is_rem;

  logic            accept;
  logic [XLEN-1:0] simple_res;
  logic [XLEN-1:0] mul_acc_next;
  logic [XLEN:0]   div_tmp;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_next;
  logic [XLEN-1:0] div_quo_next;
  logic [SHW-1:0]  shamt;

  assign in_ready = !rst && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  assign zero     = (ALUOut == '0);
  assign shamt    = ALU_src_b[SHW-1:0];

  always_comb begin
    simple_res = '0;
    case (ALUcrl)
      4'b0000: simple_res = ALU_src_a & ALU_src_b;
      4'b0001: simple_res = ALU_src_a | ALU_src_b;
      4'b0010: simple_res = ALU_src_a + ALU_src_b;
      4'b0110: simple_res = ALU_src_a - ALU_src_b;
      4'b0111: simple_res = {{(XLEN-1){1'b0}}, (ALU_src_a < ALU_src_b)};
      4'b1100: simple_res = ~(ALU_src_a | ALU_src_b);
      4'b0011: simple_res = ALU_src_a ^ ALU_src_b;
      4'b0100: simple_res = ALU_src_a << shamt;
      4'b0101: simple_res = ALU_src_a >> shamt;
      4'b1101: simple_res = $unsigned($signed(ALU_src_a) >>> shamt);
      4'b1000: simple_res = {{(XLEN-1){1'b0}}, ($signed(ALU_src_a) < $signed(ALU_src_b))};
      default: simple_res = '0;
    endcase
  end

  assign mul_acc_next = acc + (op_b[0] ? op_a : '0);

  // A zero divisor needs no special case: every step subtracts, giving an
  // all-ones quotient and a remainder equal to the dividend.
  assign div_tmp      = {acc, op_a[XLEN-1]};
  assign div_ge       = (div_tmp >= {1'b0, op_b});
  assign div_rem_next = div_ge ? (div_tmp[XLEN-1:0] - op_b) : div_tmp[XLEN-1:0];
  assign div_quo_next = {op_a[XLEN-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ALUOut    <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      is_rem    <= 1'b0;
    end else if (accept) begin
      op_a   <= ALU_src_a;
      op_b   <= ALU_src_b;
      acc    <= '0;
      cnt    <= SHW'(XLEN - 1);
      is_rem <= (ALUcrl == 4'b1011);
      case (ALUcrl)
        4'b1001: begin
          state     <= S_MUL;
          out_valid <= 1'b0;
        end
        4'b1010, 4'b1011: begin
          state     <= S_DIV;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= S_HOLD;
          ALUOut    <= simple_res;
          out_valid <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_MUL: begin
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          acc  <= mul_acc_next;
          if (cnt == '0) begin
            ALUOut    <= mul_acc_next;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          op_a <= div_quo_next;
          acc  <= div_rem_next;
          if (cnt == '0) begin
            ALUOut    <= is_rem ? div_rem_next : div_quo_next;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_seq.sv
// Directed self-checking bench for execute_seq (XLEN = 32).
module tb_execute_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ALUcrl;
  logic [XLEN-1:0] ALU_src_a;
  logic [XLEN-1:0] ALU_src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALUOut;
  logic            zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  execute_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUcrl    (ALUcrl),
    .ALU_src_a (ALU_src_a),
    .ALU_src_b (ALU_src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOut    (ALUOut),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_iter(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    int lat;
    logic rdy_err;
    ALUcrl = op; ALU_src_a = a; ALU_src_b = b; in_valid = 1'b1;
    #1;
    check({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    step();
    in_valid  = 1'b0;
    ALUcrl    = 4'b0010;
    ALU_src_a = ~a;
    ALU_src_b = 32'h3;
    lat = 0;
    rdy_err = 1'b0;
    while (lat < 40) begin
      step();
      lat++;
      if (out_valid) break;
      if (in_ready) rdy_err = 1'b1;
    end
    check({nm, "_latency"}, lat, 32);
    check({nm, "_result"}, ALUOut, exp);
    check({nm, "_busy_not_ready"}, {31'b0, rdy_err}, 32'd0);
  endtask

  initial begin
    logic stable;
    logic rose;

    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000};
    vecs[2]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    vecs[3]  = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[4]  = '{4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000};
    vecs[5]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[6]  = '{4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000};
    vecs[7]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[8]  = '{4'b0001, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F};
    vecs[9]  = '{4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    vecs[10] = '{4'b0101, 32'h80000000, 32'h00000024, 32'h08000000};
    vecs[11] = '{4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[13] = '{4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h00000000};
    vecs[14] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUcrl = 4'b0000; ALU_src_a = '0; ALU_src_b = '0;
    #1;
    check("rst_in_ready_early", {31'b0, in_ready}, 32'd0);
    step();
    step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_aluout", ALUOut, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // back-to-back single-cycle ops, one result per cycle
    for (int i = 0; i < 15; i++) begin
      ALUcrl = vecs[i].op; ALU_src_a = vecs[i].a; ALU_src_b = vecs[i].b;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      step();
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d_result", i), ALUOut, vecs[i].exp);
      check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, (vecs[i].exp == 32'd0)});
    end
    in_valid = 1'b0;
    step();
    check("retire_to_idle", {31'b0, out_valid}, 32'd0);

    run_iter("mul",     4'b1001, 32'h12345678, 32'h00000010, 32'h23456780);
    run_iter("mul_neg", 4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_iter("divu",    4'b1010, 32'd100, 32'd7, 32'd14);
    run_iter("remu",    4'b1011, 32'd100, 32'd7, 32'd2);
    run_iter("divu_z",  4'b1010, 32'd9, 32'd0, 32'hFFFFFFFF);
    run_iter("remu_z",  4'b1011, 32'd9, 32'd0, 32'd9);
    step();

    // backpressure
    out_ready = 1'b0;
    ALUcrl = 4'b0010; ALU_src_a = 32'd10; ALU_src_b = 32'd20; in_valid = 1'b1;
    step();
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_result", ALUOut, 32'd30);
    ALU_src_a = 32'd1; ALU_src_b = 32'd1;
    stable = 1'b1;
    repeat (5) begin
      step();
      if (ALUOut !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", {31'b0, stable}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_next_result", ALUOut, 32'd2);
    check("bp_next_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_idle", {31'b0, out_valid}, 32'd0);

    // reset in the middle of a divide
    ALUcrl = 4'b1010; ALU_src_a = 32'd100; ALU_src_b = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rose = 1'b0;
    repeat (9) begin
      step();
      if (out_valid) rose = 1'b1;
    end
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    check("midrst_aluout", ALUOut, 32'd0);
    check("midrst_zero", {31'b0, zero}, 32'd1);
    repeat (35) begin
      if (out_valid) rose = 1'b1;
      step();
    end
    check("midrst_never_valid", {31'b0, rose}, 32'd0);
    ALUcrl = 4'b0010; ALU_src_a = 32'd2; ALU_src_b = 32'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_add", ALUOut, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execute_seq.md
# execute_seq

Sequential, handshaked successor to the combinational execute ALU. It is parametrised in `XLEN` and keeps the existing 4-bit `ALUcrl` encodings with the same results. It adds XOR, shifts, signed compare, an iterative multiply, and an iterative unsigned divide/remainder. Operands enter through a valid/ready input port, and results leave through a registered valid/ready output port, so the block can sit in a stalling execute stage.

## Interface
- `XLEN`, 32, datapath width; power of two, ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and op are presented.
- `in_ready`  out  1  block accepts the operation on this edge.
- `ALUcrl`  in  4  operation select.
- `ALU_src_a`  in  XLEN  operand A.
- `ALU_src_b`  in  XLEN  operand B.
- `out_valid`  out  1  `ALUOut`/`zero` hold a result.
- `out_ready`  in  1  consumer takes the result on this edge.
- `ALUOut`  out  XLEN  registered result.
- `zero`  out  1  `ALUOut == 0`, decoded from the registered `ALUOut`.

## Operation
- **Single-cycle ops** (result computed in the accept cycle):
  - 0000 AND; 0001 OR; 0010 ADD (mod 2^XLEN); 0110 SUB (mod 2^XLEN).
  - 0111 SLTU (unsigned A<B → 1, else 0); 1100 NOR; 0011 XOR.
  - 0100 SLL, 0101 SRL, 1101 SRA: shift amount = `ALU_src_b[log2(XLEN)-1:0]`; upper bits of B are ignored.
  - 1000 SLT (signed A<B → 1, else 0).
  - 1110, 1111: result 0.
- **Iterative ops** (one step per cycle, XLEN steps):
  - 1001 MUL: low XLEN bits of A×B, shift-add.
  - 1010 DIVU: unsigned quotient, restoring division.
  - 1011 REMU: unsigned remainder, restoring division.
  - Divide by zero: DIVU → all ones; REMU → A.
- **States**: IDLE, MUL, DIV, HOLD.
  - IDLE: `in_ready`=1 and `out_valid`=0.
  - Accept of a single-cycle op → HOLD, with the result loaded into `ALUOut`.
  - Accept of MUL → MUL. Accept of DIVU/REMU → DIV.
  - Both operands and the op are latched at accept; input changes afterwards have no effect.
  - MUL/DIV: `in_ready`=0. A step counter counts XLEN steps. After the last step the result goes to `ALUOut` and the state moves to HOLD.
  - HOLD: `out_valid`=1, and `ALUOut`/`zero` stay stable until `out_ready`=1.
    - `out_ready`=1 without a new accept → IDLE.
    - `in_ready` = `out_ready`. If `out_ready`=1 and `in_valid`=1 on the same edge, the result is retired and the new op is accepted on that edge. The next state follows the new op, so back-to-back single-cycle ops give one result per cycle.
- **Reset**, effective on any edge where `rst`=1, including mid-MUL/DIV: state → IDLE, `ALUOut`=0, `zero`=1, `out_valid`=0, counter=0.
  - A partial result is discarded and never presented.
  - `in_ready`=0 while `rst`=1.

## Timing
- Acceptance edge: `in_valid & in_ready` at a rising edge.
- Single-cycle op accepted at edge k: `out_valid`=1 from edge k onward. This is 1-cycle latency.
- MUL/DIVU/REMU accepted at edge k:
  - Iteration edges k+1 … k+XLEN.
  - `out_valid`=1 from edge k+XLEN, i.e. XLEN cycles of latency.
  - Throughput: one op per XLEN+1 cycles with `out_ready` tied high.
- `out_valid` never drops without `out_ready`=1 or `rst`.
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`.
- `out_valid` is a registered state bit. `zero` is decoded from the registered `ALUOut`, so both are stable through the whole output handshake.

## Test plan
- **Reset/idle**: assert `rst` 2 cycles → `out_valid`=0, `ALUOut`=0, `zero`=1, `in_ready`=0 during reset and 1 after.
- **Legacy ops**, back-to-back with `out_ready`=1 (XLEN=32), one result per cycle in order:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 5−5 → 0, `zero`=1.
  - SLTU 1<0xFFFFFFFF → 1.
  - NOR 0,0 → 0xFFFFFFFF.
- **New single-cycle ops**:
  - SRA 0x80000000 by B=0x24 → shift amount 4 → 0xF8000000.
  - SLT 0xFFFFFFFF<1 → 1.
  - SLL 1 by 31 → 0x80000000.
- **MUL**: 0x12345678×0x10 → `out_valid` exactly 32 cycles after accept, `ALUOut`=0x23456780. `in_ready`=0 for those cycles. Operand changes after accept have no effect.
- **Divide**:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- **Backpressure and reset**:
  - Hold `out_ready`=0 for 5 cycles after a result → `ALUOut` stable, `in_ready`=0.
  - Pulse `rst` at step 10 of a DIVU → `out_valid` never rises; the next ADD 2+3 → 5 after 1 cycle.
